// File: rtl/instr_fetch_pkg.sv
// Shared defines for the fetch stage and the control decoder:
// the word width, the HLT opcode and the bubble encoding.
package instr_fetch_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [WORD_W-1:0] INSTR_NOP_WORD = 16'h0000;

    typedef logic [WORD_W-1:0] wordT;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetchStateE;

    function automatic logic isHalt(input wordT word);
        return (word[WORD_W-1:WORD_W-4] == OPC_HLT);
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: a flush inserts a bubble and takes priority over hold.
module if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter wordT INSTR_NOP = INSTR_NOP_WORD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic flush,
    input  wordT instrIn,
    input  wordT pcPlus1In,
    output wordT instr,
    output wordT pcPlus1,
    output logic vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= INSTR_NOP;
            pcPlus1 <= '0;
            vld     <= 1'b0;
        end else if (flush) begin
            instr   <= INSTR_NOP;
            pcPlus1 <= '0;
            vld     <= 1'b0;
        end else if (!hold) begin
            instr   <= instrIn;
            pcPlus1 <= pcPlus1In;
            vld     <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, halt tracking and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter wordT RESET_PC  = 16'h0000,
    parameter wordT INSTR_NOP = INSTR_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] pc_plus1_out,
    output logic              instr_vld,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] stall_cnt,
    output logic [WORD_W-1:0] flush_cnt
`endif
);

    wordT       pc;
    wordT       pcPlus1;
    fetchStateE stateQ;
    fetchStateE stateD;
    logic       fetchNow;
    logic       haltFetched;

    assign pcPlus1     = pc + 16'd1;
    assign fetchNow    = !redirect && !halted && !stall;
    assign haltFetched = fetchNow && isHalt(imem_data);

    assign imem_addr  = pc;
    assign imem_rd_en = rst_n & ~halted & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= FETCH_RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            FETCH_RUN:  if (haltFetched) stateD = FETCH_HALT;
            FETCH_HALT: if (redirect)    stateD = FETCH_RUN;
            default:    stateD = FETCH_RUN;
        endcase
    end

    always_comb begin
        halted = (stateQ == FETCH_HALT);
    end

    // The PC parks on an HLT word so a later redirect is the only way out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (fetchNow && !haltFetched) begin
            pc <= pcPlus1;
        end
    end

    if_id_reg #(
        .INSTR_NOP(INSTR_NOP)
    ) ifIdReg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (halted | stall),
        .flush    (redirect),
        .instrIn  (imem_data),
        .pcPlus1In(pcPlus1),
        .instr    (instr_out),
        .pcPlus1  (pc_plus1_out),
        .vld      (instr_vld)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !redirect && !halted && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redirect && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch; define FETCH_PERF_CNT_EN to cover the counters.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] pc_plus1_out;
    logic        instr_vld;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc1;
        logic        vld;
        logic        halt;
        logic [15:0] addr;
        logic        rdEn;
    } expT;

    expT sbQ[$];
    int  vecCount = 0;
    int  errCount = 0;

    assign imem_data = mem[imem_addr];

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .pc_plus1_out(pc_plus1_out),
        .instr_vld   (instr_vld),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check16(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic pushExpect(input logic [15:0] eInstr, input logic [15:0] ePc1, input logic eVld,
                              input logic eHalt, input logic [15:0] eAddr, input logic eRdEn);
        expT e;
        e.instr = eInstr;
        e.pc1   = ePc1;
        e.vld   = eVld;
        e.halt  = eHalt;
        e.addr  = eAddr;
        e.rdEn  = eRdEn;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        if (sbQ.size() == 0) begin
            vecCount++;
            errCount++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sbQ.pop_front();
        check16(tag, "instr", instr_out, e.instr);
        if (e.vld) check16(tag, "pcPlus1", pc_plus1_out, e.pc1);
        check16(tag, "vld", {15'd0, instr_vld}, {15'd0, e.vld});
        check16(tag, "halted", {15'd0, halted}, {15'd0, e.halt});
        check16(tag, "addr", imem_addr, e.addr);
        check16(tag, "rdEn", {15'd0, imem_rd_en}, {15'd0, e.rdEn});
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc,
                         input logic [15:0] eInstr, input logic [15:0] ePc1, input logic eVld,
                         input logic eHalt, input logic [15:0] eAddr, input logic eRdEn,
                         input string tag);
        applyStimulus(st, rd, rpc);
        pushExpect(eInstr, ePc1, eVld, eHalt, eAddr, eRdEn);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {4'h1, 12'(i)};
        mem[0] = 16'h1123;
        mem[1] = 16'h2456;
        mem[7] = 16'hF000;

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        #2 rst_n = 1'b0;
        #10;
        pushExpect(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset");
        pushExpect(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("resetHold");
        rst_n = 1'b1;

        cycle(0, 0, 0, 16'h1123, 16'd1, 1, 0, 16'd1, 1, "fetch0");
        cycle(0, 0, 0, 16'h2456, 16'd2, 1, 0, 16'd2, 1, "fetch1");
        for (int a = 2; a < 5; a++)
            cycle(0, 0, 0, mem[a], 16'(a + 1), 1, 0, 16'(a + 1), 1, "seq");

        for (int k = 0; k < 3; k++)
            cycle(1, 0, 0, mem[4], 16'd5, 1, 0, 16'd5, 0, "stallHold");
        cycle(0, 0, 0, mem[5], 16'd6, 1, 0, 16'd6, 1, "stallRelease");
        cycle(0, 0, 0, mem[6], 16'd7, 1, 0, 16'd7, 1, "preHalt");

        cycle(0, 0, 0, 16'hF000, 16'd8, 1, 1, 16'd7, 0, "haltCapture");
        for (int k = 0; k < 10; k++)
            cycle(0, 0, 0, 16'hF000, 16'd8, 1, 1, 16'd7, 0, "haltHold");
        cycle(0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0, 16'h0010, 1, "haltRedirect");
        cycle(0, 0, 0, mem[16'h0010], 16'h0011, 1, 0, 16'h0011, 1, "resume");

        cycle(1, 1, 16'h0040, 16'h0000, 16'h0000, 0, 0, 16'h0040, 0, "redirectInStall");
        cycle(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 0, "bubbleHold");
`ifdef FETCH_PERF_CNT_EN
        check16("perf", "stallCnt", stall_cnt, 16'd4);
        check16("perf", "flushCnt", flush_cnt, 16'd2);
`endif
        cycle(0, 0, 0, mem[16'h0040], 16'h0041, 1, 0, 16'h0041, 1, "targetFetch");

        cycle(0, 1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 1, "toTop");
        cycle(0, 0, 0, mem[16'hFFFF], 16'h0000, 1, 0, 16'h0000, 1, "wrap");
        cycle(0, 0, 0, 16'h1123, 16'd1, 1, 0, 16'd1, 1, "afterWrap");

        applyStimulus(1'b1, 1'b0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        pushExpect(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("asyncReset");
`ifdef FETCH_PERF_CNT_EN
        check16("asyncReset", "stallCnt", stall_cnt, 16'd0);
        check16("asyncReset", "flushCnt", flush_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 16'h1123, 16'd1, 1, 0, 16'd1, 1, "postReset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
